alu_share_arb: RTL and testbench
================================

Name: alu_share_arb

Overview:
Shares one combinational ALU (opcodes 0-9: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU) between NUM_REQ requesters, e.g. the execute stage and a branch/address helper.
Uses round-robin arbitration and a valid/ready handshake on both request and response sides.
Registers the operands before they drive the ALU, then captures the result and flags.
Holds the result until the owning requester accepts it.

Parameters:
NUM_REQ, 2, number of requesters (legal 2..8)
DATA_W, 32, operand/result width (ALU is 32-bit; only 32 supported)
ID_W, $clog2(NUM_REQ), requester index width (derived, not overridable)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester operation request
req_ready  out  NUM_REQ  per-requester request accepted (one-hot or zero)
req_a  in  NUM_REQ*DATA_W  operand A, requester i at [i*32 +: 32]
req_b  in  NUM_REQ*DATA_W  operand B / immediate
req_op  in  NUM_REQ*4  ALU opcode
rsp_valid  out  NUM_REQ  result valid, one-hot to the owning requester
rsp_ready  in  NUM_REQ  requester accepts result
rsp_q  out  DATA_W  result
rsp_zero  out  1  captured Zero flag
rsp_neg  out  1  captured Neg flag
rsp_ovf  out  1  captured Overflow flag
rsp_illegal  out  1  opcode was >9 (ALU returned 0)
alu_a  out  DATA_W  to ALU A
alu_b  out  DATA_W  to ALU B
alu_opcode  out  4  to ALU Opcode
alu_q  in  DATA_W  from ALU Q
alu_zero  in  1  from ALU Zero
alu_neg  in  1  from ALU Neg
alu_overflow  in  1  from ALU Overflow

Behaviour:
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- Reset values: rr_ptr=0, all operand/result registers 0, req_ready=0, rsp_valid=0. Flags, rsp_q and alu_* are therefore 0 during reset.
- IDLE:
  - Grant goes to the first requester with req_valid=1, searching from rr_ptr upward with wrap at NUM_REQ-1 -> 0.
  - req_ready[grant]=1 combinationally in that same cycle; all other req_ready bits are 0.
  - On the clock edge: capture a/b/op and grant id, set rr_ptr = grant+1 (mod NUM_REQ), go to EXEC.
  - With no valid requests: stay in IDLE, rr_ptr unchanged.
- EXEC (exactly one cycle):
  - alu_a/alu_b/alu_opcode are driven from the operand registers. They are stable for the whole EXEC cycle and hold their value in every state.
  - On the edge: capture alu_q, alu_zero, alu_neg and alu_overflow into result registers. Set the illegal bit if op>9. Go to RESP.
- RESP:
  - rsp_valid[id]=1 and the rsp_* outputs come from the result registers.
  - Leave for IDLE on the edge where rsp_ready[id]=1.
  - rsp_ready on other indices is ignored.
- Latency: request accept edge -> rsp_valid high 2 cycles later. Minimum issue interval is 3 cycles per operation.
- A requester may issue its next request while its own response is pending. That request is not accepted until the FSM is back in IDLE.
- req_ready is never asserted outside IDLE.
- Requester rule: a/b/op must be held stable while req_valid=1 and req_ready=0. The arbiter samples only on the accept edge.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1. No requester waits more than NUM_REQ-1 grants.
- Illegal opcodes are forwarded unchanged. The response is rsp_q=0, rsp_zero=1, rsp_illegal=1.
- Reset asserted mid-operation: return to IDLE immediately (asynchronous). The in-flight operation and response are discarded and no rsp_valid is produced after reset release.
- Single-requester config: only NUM_REQ>=2 is supported. Elaboration fails otherwise.

Decomposition:
- Shared package alu_pkg holds:
  - enum alu_op_e (ADD=0 … SLTU=9)
  - localparam ALU_OP_MAX=9
  - typedef arb_state_e {IDLE, EXEC, RESP}
  - struct alu_req_t {a, b, op}
- One sub-module, rr_arbiter (NUM_REQ request vector + pointer -> one-hot grant and index). Purely combinational, reusable for future shared resources.

Test Plan:
1. Req0 ADD a=5, b=7 alone -> req_ready[0] high in the same cycle; 2 cycles later rsp_valid=01, rsp_q=12, zero=0, neg=0, illegal=0.
2. Req0 and req1 both valid continuously (SUB 3-5 / SLTU 3,5) -> grants alternate 0,1,0,1. Req0 gets rsp_q=0xFFFFFFFE with neg=1; req1 gets rsp_q=1.
3. Response backpressure: rsp_ready[1]=0 for 4 cycles -> rsp_valid and rsp_q held constant, req_ready stays 0. Accept on cycle 5 -> IDLE next cycle.
4. Opcode 12, a=0xFFFF0000, b=1 -> rsp_q=0, rsp_zero=1, rsp_illegal=1.
5. Reset during EXEC of SRA 0x80000000>>>4 -> all rsp_valid and req_ready are 0 at once. After release there is no response and rr_ptr=0 (first grant goes to req0).
6. NUM_REQ=4, all valid, rr_ptr=3 -> grant order 3,0,1,2. Requesters 1 and 3 only valid -> order 1,3,1,3.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the ALU-sharing arbiter: opcodes, FSM states and the
// operand/result bundles that are registered around the external ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  localparam logic [3:0] ALU_OP_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
  } alu_req_t;

  typedef struct packed {
    logic [31:0] q;
    logic        zero;
    logic        neg;
    logic        ovf;
    logic        illegal;
  } alu_rsp_t;

  function automatic logic op_illegal(input logic [3:0] op);
    return op > ALU_OP_MAX;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr,
// wrapping at NUM_REQ-1, as a one-hot grant plus its index.
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] gnt_id,
  output logic                       gnt_vld
);

  localparam int ID_W = $clog2(NUM_REQ);

  int idx;

  // Scan farthest-from-ptr first so the closest valid requester wins last.
  always_comb begin
    gnt_id  = '0;
    gnt_vld = 1'b0;
    idx     = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (req[idx]) begin
        gnt_id  = ID_W'(idx);
        gnt_vld = 1'b1;
      end
    end
    gnt = '0;
    if (gnt_vld) gnt[gnt_id] = 1'b1;
  end

endmodule

// File: rtl/alu_share_arb.sv
// Time-shares one external combinational ALU between NUM_REQ requesters:
// round-robin grant, registered operands, registered result held until taken.
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]   req_a,
  input  logic [NUM_REQ*DATA_W-1:0]   req_b,
  input  logic [NUM_REQ*4-1:0]        req_op,
  output logic [NUM_REQ-1:0]          rsp_valid,
  input  logic [NUM_REQ-1:0]          rsp_ready,
  output logic [DATA_W-1:0]           rsp_q,
  output logic                        rsp_zero,
  output logic                        rsp_neg,
  output logic                        rsp_ovf,
  output logic                        rsp_illegal,
  output logic [DATA_W-1:0]           alu_a,
  output logic [DATA_W-1:0]           alu_b,
  output logic [3:0]                  alu_opcode,
  input  logic [DATA_W-1:0]           alu_q,
  input  logic                        alu_zero,
  input  logic                        alu_neg,
  input  logic                        alu_overflow
);

  localparam int ID_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("alu_share_arb: NUM_REQ must be in 2..8");
  end
  if (DATA_W != 32) begin : g_bad_data_w
    $error("alu_share_arb: only DATA_W=32 is supported");
  end

  arb_state_e state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] id_q, id_d;
  alu_req_t        opnd_q, opnd_d;
  alu_rsp_t        res_q, res_d;

  logic [NUM_REQ-1:0][DATA_W-1:0] a_lane, b_lane;
  logic [NUM_REQ-1:0][3:0]        op_lane;
  assign a_lane  = req_a;
  assign b_lane  = req_b;
  assign op_lane = req_op;

  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_id;
  logic               gnt_vld;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .gnt_vld (gnt_vld)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      opnd_q   <= '0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      opnd_q   <= opnd_d;
      res_q    <= res_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    opnd_d   = opnd_q;
    res_d    = res_q;
    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          opnd_d.a  = a_lane[gnt_id];
          opnd_d.b  = b_lane[gnt_id];
          opnd_d.op = op_lane[gnt_id];
          id_d      = gnt_id;
          rr_ptr_d  = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        res_d.q       = alu_q;
        res_d.zero    = alu_zero;
        res_d.neg     = alu_neg;
        res_d.ovf     = alu_overflow;
        res_d.illegal = op_illegal(opnd_q.op);
        state_d       = RESP;
      end
      RESP: begin
        if (rsp_ready[id_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // req_ready is gated by rst_n so no grant is advertised while held in reset.
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (state_q == IDLE && rst_n) req_ready = gnt;
    if (state_q == RESP) rsp_valid[id_q] = 1'b1;
  end

  assign rsp_q       = res_q.q;
  assign rsp_zero    = res_q.zero;
  assign rsp_neg     = res_q.neg;
  assign rsp_ovf     = res_q.ovf;
  assign rsp_illegal = res_q.illegal;
  assign alu_a       = opnd_q.a;
  assign alu_b       = opnd_q.b;
  assign alu_opcode  = opnd_q.op;

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: a 2-requester DUT driven from a vector table and
// scoreboard, plus a 4-requester DUT for rotation order.
module tb_alu_share_arb;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  typedef struct packed {logic [31:0] q; logic z; logic n; logic o;} res_t;

  function automatic res_t alu_model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    res_t r;
    r.q = '0;
    r.o = 1'b0;
    case (op)
      4'd0: begin r.q = a + b; r.o = (a[31] == b[31]) && (r.q[31] != a[31]); end
      4'd1: begin r.q = a - b; r.o = (a[31] != b[31]) && (r.q[31] != a[31]); end
      4'd2: r.q = a & b;
      4'd3: r.q = a | b;
      4'd4: r.q = a ^ b;
      4'd5: r.q = a << b[4:0];
      4'd6: r.q = a >> b[4:0];
      4'd7: r.q = $unsigned($signed(a) >>> b[4:0]);
      4'd8: r.q = {31'b0, $signed(a) < $signed(b)};
      4'd9: r.q = {31'b0, a < b};
      default: r.q = '0;
    endcase
    r.z = (r.q == 32'd0);
    r.n = r.q[31];
    return r;
  endfunction

  // 2-requester DUT
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [63:0] req_a, req_b;
  logic [7:0]  req_op;
  logic [31:0] rsp_q, alu_a, alu_b, alu_q;
  logic        rsp_zero, rsp_neg, rsp_ovf, rsp_illegal;
  logic [3:0]  alu_opcode;
  logic        alu_zero, alu_neg, alu_overflow;
  res_t        r2;
  assign r2 = alu_model(alu_a, alu_b, alu_opcode);
  assign alu_q = r2.q;
  assign alu_zero = r2.z;
  assign alu_neg = r2.n;
  assign alu_overflow = r2.o;

  alu_share_arb #(.NUM_REQ(2), .DATA_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_q(rsp_q), .rsp_zero(rsp_zero), .rsp_neg(rsp_neg),
    .rsp_ovf(rsp_ovf), .rsp_illegal(rsp_illegal),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_q(alu_q), .alu_zero(alu_zero), .alu_neg(alu_neg),
    .alu_overflow(alu_overflow)
  );

  // 4-requester DUT
  logic [3:0]   req_valid4, req_ready4, rsp_valid4, rsp_ready4;
  logic [127:0] req_a4, req_b4;
  logic [15:0]  req_op4;
  logic [31:0]  rsp_q4, alu_a4, alu_b4;
  logic         rsp_zero4, rsp_neg4, rsp_ovf4, rsp_illegal4;
  logic [3:0]   alu_op4;
  res_t         r4;
  assign r4 = alu_model(alu_a4, alu_b4, alu_op4);

  alu_share_arb #(.NUM_REQ(4), .DATA_W(32)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid4), .req_ready(req_ready4),
    .req_a(req_a4), .req_b(req_b4), .req_op(req_op4),
    .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4),
    .rsp_q(rsp_q4), .rsp_zero(rsp_zero4), .rsp_neg(rsp_neg4),
    .rsp_ovf(rsp_ovf4), .rsp_illegal(rsp_illegal4),
    .alu_a(alu_a4), .alu_b(alu_b4), .alu_opcode(alu_op4),
    .alu_q(r4.q), .alu_zero(r4.z), .alu_neg(r4.n),
    .alu_overflow(r4.o)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int oh2i(input logic [3:0] v);
    int k = -1;
    for (int i = 0; i < 4; i++) if (v[i]) k = i;
    return k;
  endfunction

  initial forever begin @(posedge clk); cyc++; end

  // Grant-order logs
  int gq2[$];
  int gq4[$];
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (req_ready != 0) gq2.push_back(oh2i({2'b00, req_ready}));
      if (req_ready4 != 0) gq4.push_back(oh2i(req_ready4));
    end
  end

  // Scoreboard for the 2-requester DUT
  typedef struct {int id; logic [31:0] q; logic z; logic n; logic o; logic ill; int cyc;} exp_t;
  exp_t sbq[$];
  initial begin
    exp_t e;
    res_t r;
    logic prev_rv = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sbq.delete();
        prev_rv = 1'b0;
      end else begin
        for (int i = 0; i < 2; i++) begin
          if (req_valid[i] && req_ready[i]) begin
            r = alu_model(req_a[i*32 +: 32], req_b[i*32 +: 32], req_op[i*4 +: 4]);
            e.id = i; e.q = r.q; e.z = r.z; e.n = r.n; e.o = r.o;
            e.ill = (req_op[i*4 +: 4] > 4'd9);
            e.cyc = cyc;
            sbq.push_back(e);
          end
        end
        if (rsp_valid != 0 && !prev_rv) begin
          if (sbq.size() == 0) chk("sb_unexpected_rsp", rsp_valid, 0);
          else chk("sb_latency", cyc, sbq[0].cyc + 2);
        end
        if ((rsp_valid & rsp_ready) != 0) begin
          if (sbq.size() == 0) chk("sb_unexpected_hs", rsp_valid, 0);
          else begin
            e = sbq.pop_front();
            chk("sb_id", rsp_valid, 2'b01 << e.id);
            chk("sb_q", rsp_q, e.q);
            chk("sb_zero", rsp_zero, e.z);
            chk("sb_neg", rsp_neg, e.n);
            chk("sb_ovf", rsp_ovf, e.o);
            chk("sb_illegal", rsp_illegal, e.ill);
          end
        end
        prev_rv = (rsp_valid != 0);
      end
    end
  end

  typedef struct {int id; logic [31:0] a; logic [31:0] b; logic [3:0] op;
                  logic [31:0] q; logic z; logic n; logic o; logic ill;} vec_t;

  task automatic apply(input int k, input vec_t v);
    @(posedge clk); #1;
    req_valid = '0;
    req_valid[v.id] = 1'b1;
    req_a[v.id*32 +: 32] = v.a;
    req_b[v.id*32 +: 32] = v.b;
    req_op[v.id*4 +: 4] = v.op;
    #1 chk($sformatf("v%0d_ready", k), req_ready, 2'b01 << v.id);
    @(posedge clk); #1;
    req_valid = '0; req_a = '1; req_b = '1; req_op = '1;
    chk($sformatf("v%0d_alu_a", k), alu_a, v.a);
    chk($sformatf("v%0d_alu_b", k), alu_b, v.b);
    chk($sformatf("v%0d_alu_op", k), alu_opcode, v.op);
    chk($sformatf("v%0d_exec_ready", k), req_ready, 0);
    @(posedge clk); #1;
    chk($sformatf("v%0d_rsp_valid", k), rsp_valid, 2'b01 << v.id);
    chk($sformatf("v%0d_q", k), rsp_q, v.q);
    chk($sformatf("v%0d_flags", k), {rsp_zero, rsp_neg, rsp_ovf, rsp_illegal}, {v.z, v.n, v.o, v.ill});
    @(posedge clk);
  endtask

  task automatic drain(input string nm);
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      if (sbq.size() == 0 && rsp_valid == 0) break;
    end
    chk(nm, sbq.size(), 0);
  endtask

  task automatic issue4(input int id);
    logic found = 1'b0;
    @(posedge clk); #1;
    req_valid4 = 4'b0001 << id;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (req_ready4[id]) begin found = 1'b1; break; end
    end
    chk($sformatf("t6_issue%0d", id), found, 1);
    @(posedge clk); #1;
    req_valid4 = '0;
    repeat (3) @(posedge clk);
  endtask

  task automatic run4(input logic [3:0] mask, input string nm, input int e0, input int e1, input int e2, input int e3);
    int exp_ord[4];
    exp_ord = '{e0, e1, e2, e3};
    gq4.delete();
    @(posedge clk); #1;
    req_valid4 = mask;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      if (gq4.size() >= 4) break;
    end
    #1 req_valid4 = '0;
    chk({nm, "_ngrants"}, gq4.size() >= 4, 1);
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s_grant%0d", nm, i), (gq4.size() > i) ? gq4[i] : -1, exp_ord[i]);
    repeat (4) @(posedge clk);
  endtask

  vec_t vt[13];

  initial begin
    vt[0]  = '{0, 32'd5,        32'd7,    4'd0,  32'd12,       1'b0, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{1, 32'd3,        32'd5,    4'd1,  32'hFFFFFFFE, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[2]  = '{0, 32'h80000000, 32'd4,    4'd7,  32'hF8000000, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[3]  = '{1, 32'hFFFF0000, 32'd1,    4'd12, 32'd0,        1'b1, 1'b0, 1'b0, 1'b1};
    vt[4]  = '{0, 32'hF0,       32'h0F,   4'd2,  32'd0,        1'b1, 1'b0, 1'b0, 1'b0};
    vt[5]  = '{1, 32'd1,        32'd31,   4'd5,  32'h80000000, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[6]  = '{0, 32'h80000000, 32'd31,   4'd6,  32'd1,        1'b0, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{1, 32'hFFFFFFFF, 32'd1,    4'd8,  32'd1,        1'b0, 1'b0, 1'b0, 1'b0};
    vt[8]  = '{0, 32'hFFFFFFFF, 32'd1,    4'd9,  32'd0,        1'b1, 1'b0, 1'b0, 1'b0};
    vt[9]  = '{1, 32'h7FFFFFFF, 32'd1,    4'd0,  32'h80000000, 1'b0, 1'b1, 1'b1, 1'b0};
    vt[10] = '{0, 32'hA,        32'h5,    4'd3,  32'hF,        1'b0, 1'b0, 1'b0, 1'b0};
    vt[11] = '{1, 32'hFF,       32'h0F,   4'd4,  32'hF0,       1'b0, 1'b0, 1'b0, 1'b0};
    vt[12] = '{0, 32'd0,        32'd0,    4'd15, 32'd0,        1'b1, 1'b0, 1'b0, 1'b1};

    rst_n = 1'b0;
    req_valid = 2'b11; req_a = '0; req_b = '0; req_op = '0; rsp_ready = 2'b11;
    req_valid4 = '0; rsp_ready4 = 4'hF;
    for (int i = 0; i < 4; i++) begin
      req_a4[i*32 +: 32] = 32'(i + 1);
      req_b4[i*32 +: 32] = 32'd10;
      req_op4[i*4 +: 4]  = 4'd0;
    end

    // Reset state, with requests pending
    #3;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_q", rsp_q, 0);
    chk("rst_flags", {rsp_zero, rsp_neg, rsp_ovf, rsp_illegal}, 0);
    chk("rst_alu", {alu_a, alu_b, alu_opcode}, 0);
    req_valid = '0;
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;

    // Single-requester vectors
    for (int i = 0; i < 13; i++) apply(i, vt[i]);
    drain("t1_drain");

    // Both valid continuously: grants alternate from requester 0
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    gq2.delete();
    req_a = {32'd3, 32'd3}; req_b = {32'd5, 32'd5}; req_op = {4'd9, 4'd1};
    req_valid = 2'b11;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      if (gq2.size() >= 4) break;
    end
    #1 req_valid = '0;
    chk("t2_ngrants", gq2.size() >= 4, 1);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t2_grant%0d", i), (gq2.size() > i) ? gq2[i] : -1, i % 2);
    drain("t2_drain");

    // Response backpressure on requester 1; requester 0 waits meanwhile
    @(posedge clk); #1;
    rsp_ready = 2'b01;
    req_a[63:32] = 32'd100; req_b[63:32] = 32'd23; req_op[7:4] = 4'd0;
    req_valid = 2'b10;
    @(posedge clk); #1;
    req_valid = 2'b01;
    req_a[31:0] = 32'hFF; req_b[31:0] = 32'h0F; req_op[3:0] = 4'd4;
    chk("t3_exec_ready", req_ready, 0);
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("t3_hold_valid%0d", k), rsp_valid, 2'b10);
      chk($sformatf("t3_hold_q%0d", k), rsp_q, 32'd123);
      chk($sformatf("t3_hold_ready%0d", k), req_ready, 0);
      @(posedge clk);
    end
    #1 rsp_ready = 2'b11;
    chk("t3_last_valid", rsp_valid, 2'b10);
    @(posedge clk); #1;
    chk("t3_idle_rsp", rsp_valid, 0);
    chk("t3_idle_ready", req_ready, 2'b01);
    @(posedge clk); #1 req_valid = '0;
    drain("t3_drain");

    // Reset during EXEC discards the operation and rewinds the pointer
    @(posedge clk); #1;
    req_a[31:0] = 32'h80000000; req_b[31:0] = 32'd4; req_op[3:0] = 4'd7;
    req_valid = 2'b01;
    @(posedge clk); #1;
    req_valid = 2'b11;
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rsp_valid", rsp_valid, 0);
    chk("t5_req_ready", req_ready, 0);
    chk("t5_alu_a", alu_a, 0);
    req_valid = '0;
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("t5_no_rsp%0d", k), rsp_valid, 0);
    end
    req_valid = 2'b11;
    #1 chk("t5_first_grant", req_ready, 2'b01);
    @(posedge clk); #1 req_valid = '0;
    drain("t5_drain");

    // 4 requesters: rotation from rr_ptr=3, then only 1 and 3
    issue4(2);
    run4(4'b1111, "t6a", 3, 0, 1, 2);
    issue4(0);
    run4(4'b1010, "t6b", 1, 3, 1, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL timeout: got no end of test, expected finish before 200000");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "timeout");
  end

endmodule
